// File: rtl/multdiv_arb_pkg.sv
// Shared types and constants for the dual-lane mult/div arbiter.
package multdiv_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        DRAIN
    } arbState;

    localparam logic LANE_TOP = 1'b0;
    localparam logic LANE_BOT = 1'b1;

    localparam int TIMEOUT_DEFAULT = 64;

    // Everything latched from one decode lane when its request is accepted.
    typedef struct packed {
        logic        isMult;
        logic [31:0] opA;
        logic [31:0] opB;
        logic [4:0]  rd;
    } laneReq;

endpackage

// File: rtl/multdiv_watchdog.sv
// Clearable up-counter that flags when the mult/div unit has taken too long.
module multdiv_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TERMINAL_COUNT = CW'(TIMEOUT - 1);

    logic [CW-1:0] countReg;

    assign terminal = (countReg == TERMINAL_COUNT);

    // Count while enabled, saturating at the terminal value.
    always_ff @(posedge clock) begin
        if (!reset) begin
            countReg <= '0;
        end else if (clear) begin
            countReg <= '0;
        end else if (enable && !terminal) begin
            countReg <= countReg + 1'b1;
        end
    end

endmodule

// File: rtl/multdiv_arbiter.sv
// Shares one iterative mult/div unit between the top and bottom issue lanes,
// issuing in program order and tagging each result with its lane and rd.
module multdiv_arbiter
    import multdiv_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_top,
    input  logic        valid_bot,
    input  logic        isMult_top,
    input  logic        isDiv_top,
    input  logic        isMult_bot,
    input  logic        isDiv_bot,
    input  logic [31:0] opA_top,
    input  logic [31:0] opB_top,
    input  logic [31:0] opA_bot,
    input  logic [31:0] opB_bot,
    input  logic [4:0]  rd_top,
    input  logic [4:0]  rd_bot,
    input  logic        flush,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_lane,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception,
    output logic        busy
);

    arbState     stateReg;
    logic        pendTopReg;
    logic        pendBotReg;
    logic        curLaneReg;
    logic [31:0] dataReg;
    logic        excReg;
    laneReq      laneReg [2];

    logic   reqTop;
    logic   reqBot;
    logic   anyReq;
    logic   issueLane;
    logic   opLane;
    logic   opsActive;
    logic   otherPend;
    logic   wdEnable;
    logic   wdTerminal;
    laneReq selReq;

    assign reqTop    = valid_top & (isMult_top | isDiv_top);
    assign reqBot    = valid_bot & (isMult_bot | isDiv_bot);
    assign anyReq    = reqTop | reqBot;
    assign issueLane = pendTopReg ? LANE_TOP : LANE_BOT;
    assign opLane    = (stateReg == ISSUE) ? issueLane : curLaneReg;
    assign selReq    = laneReg[opLane];
    assign otherPend = (curLaneReg == LANE_TOP) ? pendBotReg : pendTopReg;

    // The unit keeps running after a flush, so operands stay up through DRAIN.
    assign opsActive = (stateReg == ISSUE) || (stateReg == WAIT) || (stateReg == DRAIN);
    assign wdEnable  = (stateReg == WAIT) || (stateReg == DRAIN);

    multdiv_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .clear    (!wdEnable),
        .enable   (wdEnable),
        .terminal (wdTerminal)
    );

    assign md_ctrl_mult = (stateReg == ISSUE) &  selReq.isMult;
    assign md_ctrl_div  = (stateReg == ISSUE) & ~selReq.isMult;
    assign md_opA       = opsActive ? selReq.opA : 32'd0;
    assign md_opB       = opsActive ? selReq.opB : 32'd0;

    assign wb_valid     = (stateReg == DONE) & ~flush;
    assign wb_lane      = wb_valid ? curLaneReg : LANE_TOP;
    assign wb_rd        = wb_valid ? laneReg[curLaneReg].rd : 5'd0;
    assign wb_data      = wb_valid ? dataReg : 32'd0;
    assign wb_exception = wb_valid ? excReg : 1'b0;
    assign busy         = (stateReg != IDLE);

    // Decode stall: held until the last pending op of the bundle is written back.
    always_comb begin
        stall = 1'b0;
        case (stateReg)
            IDLE:        stall = anyReq & ~flush;
            ISSUE, WAIT: stall = 1'b1;
            DONE:        stall = otherPend;
            DRAIN:       stall = anyReq;
            default:     stall = 1'b0;
        endcase
    end

    // Arbitration FSM: latch bundle, issue top then bot, wait, write back.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stateReg   <= IDLE;
            pendTopReg <= 1'b0;
            pendBotReg <= 1'b0;
            curLaneReg <= LANE_TOP;
            dataReg    <= 32'd0;
            excReg     <= 1'b0;
            laneReg[0] <= '0;
            laneReg[1] <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (anyReq && !flush) begin
                        pendTopReg <= reqTop;
                        pendBotReg <= reqBot;
                        laneReg[LANE_TOP] <= '{isMult: isMult_top, opA: opA_top,
                                               opB: opB_top, rd: rd_top};
                        laneReg[LANE_BOT] <= '{isMult: isMult_bot, opA: opA_bot,
                                               opB: opB_bot, rd: rd_bot};
                        stateReg <= ISSUE;
                    end
                end
                ISSUE: begin
                    curLaneReg <= issueLane;
                    if (flush) begin
                        pendTopReg <= 1'b0;
                        pendBotReg <= 1'b0;
                        stateReg   <= DRAIN;
                    end else begin
                        stateReg <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        pendTopReg <= 1'b0;
                        pendBotReg <= 1'b0;
                        // A result landing in the flush cycle already frees the unit.
                        stateReg   <= (md_resultRDY || wdTerminal) ? IDLE : DRAIN;
                    end else if (md_resultRDY) begin
                        dataReg  <= md_result;
                        excReg   <= md_exception;
                        stateReg <= DONE;
                    end else if (wdTerminal) begin
                        dataReg  <= 32'd0;
                        excReg   <= 1'b1;
                        stateReg <= DONE;
                    end
                end
                DONE: begin
                    if (flush) begin
                        pendTopReg <= 1'b0;
                        pendBotReg <= 1'b0;
                        stateReg   <= IDLE;
                    end else begin
                        if (curLaneReg == LANE_TOP) begin
                            pendTopReg <= 1'b0;
                        end else begin
                            pendBotReg <= 1'b0;
                        end
                        stateReg <= otherPend ? ISSUE : IDLE;
                    end
                end
                DRAIN: begin
                    if (md_resultRDY || wdTerminal) begin
                        stateReg <= IDLE;
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_arbiter.sv
// Directed testbench for multdiv_arbiter with a hand-driven mult/div unit.
module tb_multdiv_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_top, valid_bot;
    logic        isMult_top, isDiv_top, isMult_bot, isDiv_bot;
    logic [31:0] opA_top, opB_top, opA_bot, opB_bot;
    logic [4:0]  rd_top, rd_bot;
    logic        flush;
    logic        md_ctrl_mult, md_ctrl_div;
    logic [31:0] md_opA, md_opB;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    logic        stall;
    logic        wb_valid;
    logic        wb_lane;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;
    logic        busy;

    int nChecks = 0;
    int nFail   = 0;

    always #5 clock = ~clock;

    multdiv_arbiter #(
        .TIMEOUT (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .valid_top    (valid_top),
        .valid_bot    (valid_bot),
        .isMult_top   (isMult_top),
        .isDiv_top    (isDiv_top),
        .isMult_bot   (isMult_bot),
        .isDiv_bot    (isDiv_bot),
        .opA_top      (opA_top),
        .opB_top      (opB_top),
        .opA_bot      (opA_bot),
        .opB_bot      (opB_bot),
        .rd_top       (rd_top),
        .rd_bot       (rd_bot),
        .flush        (flush),
        .md_ctrl_mult (md_ctrl_mult),
        .md_ctrl_div  (md_ctrl_div),
        .md_opA       (md_opA),
        .md_opB       (md_opB),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_resultRDY (md_resultRDY),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_lane      (wb_lane),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_exception (wb_exception),
        .busy         (busy)
    );

    // One line per writeback transaction.
    always @(negedge clock) begin
        if (wb_valid)
            $display("wb lane=%0d rd=%0d data=%0d exc=%0b", wb_lane, wb_rd, wb_data, wb_exception);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clearInputs();
        valid_top = 0; valid_bot = 0;
        isMult_top = 0; isDiv_top = 0; isMult_bot = 0; isDiv_bot = 0;
        opA_top = 0; opB_top = 0; opA_bot = 0; opB_bot = 0;
        rd_top = 0; rd_bot = 0; flush = 0;
        md_result = 0; md_exception = 0; md_resultRDY = 0;
    endtask

    task automatic test_reset();
        clearInputs();
        reset = 0;
        step();
        step();
        #1;
        nChecks++; if (busy !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b want 0", busy); end
        nChecks++; if (stall !== 1'b0) begin nFail++; $display("FAIL reset_stall: got %b want 0", stall); end
        nChecks++; if ({md_ctrl_mult, md_ctrl_div} !== 2'b00) begin nFail++; $display("FAIL reset_ctrl: got %b want 00", {md_ctrl_mult, md_ctrl_div}); end
        nChecks++; if (md_opA !== 32'd0 || md_opB !== 32'd0) begin nFail++; $display("FAIL reset_ops: got %h/%h want 0/0", md_opA, md_opB); end
        nChecks++; if ({wb_valid, wb_lane, wb_rd, wb_data, wb_exception} !== 40'd0) begin nFail++; $display("FAIL reset_wb: got %b %b %0d %h %b want all 0", wb_valid, wb_lane, wb_rd, wb_data, wb_exception); end
        reset = 1;
        step();
    endtask

    task automatic test_single();
        valid_top = 1; isMult_top = 1; opA_top = 6; opB_top = 7; rd_top = 5;
        #1;
        nChecks++; if (stall !== 1'b1) begin nFail++; $display("FAIL single_stall_req: got %b want 1", stall); end
        step();
        clearInputs();
        #1;
        nChecks++; if ({md_ctrl_mult, md_ctrl_div} !== 2'b10) begin nFail++; $display("FAIL single_start: got %b want 10", {md_ctrl_mult, md_ctrl_div}); end
        nChecks++; if (md_opA !== 32'd6 || md_opB !== 32'd7) begin nFail++; $display("FAIL single_ops: got %0d/%0d want 6/7", md_opA, md_opB); end
        step();
        for (int i = 0; i < 4; i++) begin
            nChecks++; if (stall !== 1'b1 || md_ctrl_mult !== 1'b0 || md_opA !== 32'd6 || wb_valid !== 1'b0) begin nFail++; $display("FAIL single_wait%0d: stall=%b start=%b opA=%0d wb=%b want 1 0 6 0", i, stall, md_ctrl_mult, md_opA, wb_valid); end
            step();
        end
        md_resultRDY = 1; md_result = 42;
        #1;
        nChecks++; if (stall !== 1'b1) begin nFail++; $display("FAIL single_stall_rdy: got %b want 1", stall); end
        step();
        md_resultRDY = 0; md_result = 0;
        #1;
        nChecks++; if (wb_valid !== 1'b1 || wb_lane !== 1'b0 || wb_rd !== 5'd5 || wb_data !== 32'd42 || wb_exception !== 1'b0) begin nFail++; $display("FAIL single_wb: got v=%b lane=%b rd=%0d data=%0d exc=%b want 1 0 5 42 0", wb_valid, wb_lane, wb_rd, wb_data, wb_exception); end
        nChecks++; if (stall !== 1'b0) begin nFail++; $display("FAIL single_stall_done: got %b want 0", stall); end
        step();
        #1;
        nChecks++; if (busy !== 1'b0 || wb_valid !== 1'b0 || md_opA !== 32'd0) begin nFail++; $display("FAIL single_idle: busy=%b wb=%b opA=%0d want 0 0 0", busy, wb_valid, md_opA); end
    endtask

    task automatic test_both();
        valid_top = 1; isDiv_top = 1; opA_top = 100; opB_top = 7; rd_top = 3;
        valid_bot = 1; isMult_bot = 1; opA_bot = 3; opB_bot = 4; rd_bot = 9;
        step();
        clearInputs();
        #1;
        nChecks++; if ({md_ctrl_mult, md_ctrl_div} !== 2'b01 || md_opA !== 32'd100 || md_opB !== 32'd7) begin nFail++; $display("FAIL both_top_start: ctrl=%b ops=%0d/%0d want 01 100/7", {md_ctrl_mult, md_ctrl_div}, md_opA, md_opB); end
        step(); step(); step();
        md_resultRDY = 1; md_result = 14;
        step();
        md_resultRDY = 0; md_result = 0;
        #1;
        nChecks++; if (wb_valid !== 1'b1 || wb_lane !== 1'b0 || wb_rd !== 5'd3 || wb_data !== 32'd14) begin nFail++; $display("FAIL both_top_wb: got v=%b lane=%b rd=%0d data=%0d want 1 0 3 14", wb_valid, wb_lane, wb_rd, wb_data); end
        nChecks++; if (stall !== 1'b1) begin nFail++; $display("FAIL both_top_done_stall: got %b want 1", stall); end
        step();
        #1;
        nChecks++; if ({md_ctrl_mult, md_ctrl_div} !== 2'b10 || md_opA !== 32'd3 || md_opB !== 32'd4 || wb_valid !== 1'b0) begin nFail++; $display("FAIL both_bot_start: ctrl=%b ops=%0d/%0d wb=%b want 10 3/4 0", {md_ctrl_mult, md_ctrl_div}, md_opA, md_opB, wb_valid); end
        step(); step();
        md_resultRDY = 1; md_result = 12;
        step();
        md_resultRDY = 0; md_result = 0;
        #1;
        nChecks++; if (wb_valid !== 1'b1 || wb_lane !== 1'b1 || wb_rd !== 5'd9 || wb_data !== 32'd12) begin nFail++; $display("FAIL both_bot_wb: got v=%b lane=%b rd=%0d data=%0d want 1 1 9 12", wb_valid, wb_lane, wb_rd, wb_data); end
        nChecks++; if (stall !== 1'b0) begin nFail++; $display("FAIL both_bot_done_stall: got %b want 0", stall); end
        step();
        #1;
        nChecks++; if (busy !== 1'b0) begin nFail++; $display("FAIL both_idle: got %b want 0", busy); end
    endtask

    task automatic test_timeout();
        valid_top = 1; isMult_top = 1; opA_top = 1; opB_top = 2; rd_top = 7;
        step();
        clearInputs();
        step();
        for (int i = 1; i <= 8; i++) begin
            nChecks++; if (wb_valid !== 1'b0 || busy !== 1'b1) begin nFail++; $display("FAIL timeout_wait%0d: wb=%b busy=%b want 0 1", i, wb_valid, busy); end
            step();
        end
        #1;
        nChecks++; if (wb_valid !== 1'b1 || wb_lane !== 1'b0 || wb_rd !== 5'd7 || wb_data !== 32'd0 || wb_exception !== 1'b1) begin nFail++; $display("FAIL timeout_wb: got v=%b lane=%b rd=%0d data=%0d exc=%b want 1 0 7 0 1", wb_valid, wb_lane, wb_rd, wb_data, wb_exception); end
        step();
    endtask

    task automatic test_flush();
        valid_top = 1; isMult_top = 1; opA_top = 2; opB_top = 3; rd_top = 1;
        valid_bot = 1; isMult_bot = 1; opA_bot = 4; opB_bot = 5; rd_bot = 2;
        step();
        clearInputs();
        step();
        flush = 1;
        #1;
        nChecks++; if (stall !== 1'b1) begin nFail++; $display("FAIL flush_wait_stall: got %b want 1", stall); end
        step();
        flush = 0;
        valid_bot = 1; isDiv_bot = 1; opA_bot = 50; opB_bot = 5; rd_bot = 4;
        #1;
        nChecks++; if (busy !== 1'b1 || wb_valid !== 1'b0 || stall !== 1'b1) begin nFail++; $display("FAIL flush_drain: busy=%b wb=%b stall=%b want 1 0 1", busy, wb_valid, stall); end
        step();
        md_resultRDY = 1; md_result = 99;
        #1;
        nChecks++; if (wb_valid !== 1'b0 || stall !== 1'b1) begin nFail++; $display("FAIL flush_drain_rdy: wb=%b stall=%b want 0 1", wb_valid, stall); end
        step();
        md_resultRDY = 0; md_result = 0;
        #1;
        nChecks++; if (busy !== 1'b0 || wb_valid !== 1'b0 || stall !== 1'b1) begin nFail++; $display("FAIL flush_idle: busy=%b wb=%b stall=%b want 0 0 1", busy, wb_valid, stall); end
        step();
        clearInputs();
        #1;
        nChecks++; if ({md_ctrl_mult, md_ctrl_div} !== 2'b01 || md_opA !== 32'd50 || md_opB !== 32'd5) begin nFail++; $display("FAIL flush_new_start: ctrl=%b ops=%0d/%0d want 01 50/5", {md_ctrl_mult, md_ctrl_div}, md_opA, md_opB); end
        step();
        md_resultRDY = 1; md_result = 10;
        step();
        md_resultRDY = 0; md_result = 0;
        #1;
        nChecks++; if (wb_valid !== 1'b1 || wb_lane !== 1'b1 || wb_rd !== 5'd4 || wb_data !== 32'd10) begin nFail++; $display("FAIL flush_new_wb: got v=%b lane=%b rd=%0d data=%0d want 1 1 4 10", wb_valid, wb_lane, wb_rd, wb_data); end
        step();
    endtask

    task automatic test_exception();
        valid_top = 1; isDiv_top = 1; opA_top = 5; opB_top = 0; rd_top = 6;
        valid_bot = 1; isMult_bot = 1; opA_bot = 2; opB_bot = 2; rd_bot = 8;
        step();
        clearInputs();
        step();
        md_resultRDY = 1; md_result = 32'hFFFF_FFFF; md_exception = 1;
        step();
        md_resultRDY = 0; md_result = 0; md_exception = 0;
        #1;
        nChecks++; if (wb_valid !== 1'b1 || wb_lane !== 1'b0 || wb_rd !== 5'd6 || wb_data !== 32'hFFFF_FFFF || wb_exception !== 1'b1) begin nFail++; $display("FAIL exc_top_wb: got v=%b lane=%b rd=%0d data=%h exc=%b want 1 0 6 ffffffff 1", wb_valid, wb_lane, wb_rd, wb_data, wb_exception); end
        step();
        #1;
        nChecks++; if ({md_ctrl_mult, md_ctrl_div} !== 2'b10 || md_opA !== 32'd2) begin nFail++; $display("FAIL exc_bot_start: ctrl=%b opA=%0d want 10 2", {md_ctrl_mult, md_ctrl_div}, md_opA); end
        step();
        md_resultRDY = 1; md_result = 4;
        step();
        md_resultRDY = 0; md_result = 0;
        #1;
        nChecks++; if (wb_valid !== 1'b1 || wb_lane !== 1'b1 || wb_rd !== 5'd8 || wb_data !== 32'd4 || wb_exception !== 1'b0) begin nFail++; $display("FAIL exc_bot_wb: got v=%b lane=%b rd=%0d data=%0d exc=%b want 1 1 8 4 0", wb_valid, wb_lane, wb_rd, wb_data, wb_exception); end
        step();
    endtask

    task automatic test_reset_mid();
        valid_top = 1; isMult_top = 1; opA_top = 9; opB_top = 9; rd_top = 11;
        step();
        clearInputs();
        step();
        step();
        reset = 0;
        step();
        reset = 1;
        md_resultRDY = 1; md_result = 77;
        #1;
        nChecks++; if (busy !== 1'b0 || stall !== 1'b0 || md_opA !== 32'd0 || {md_ctrl_mult, md_ctrl_div} !== 2'b00 || wb_valid !== 1'b0) begin nFail++; $display("FAIL rstmid_outputs: busy=%b stall=%b opA=%0d ctrl=%b wb=%b want all 0", busy, stall, md_opA, {md_ctrl_mult, md_ctrl_div}, wb_valid); end
        step();
        md_resultRDY = 0; md_result = 0;
        #1;
        nChecks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin nFail++; $display("FAIL rstmid_stray: wb=%b busy=%b want 0 0", wb_valid, busy); end
        valid_bot = 1; isDiv_bot = 1; opA_bot = 21; opB_bot = 3; rd_bot = 12;
        step();
        clearInputs();
        #1;
        nChecks++; if ({md_ctrl_mult, md_ctrl_div} !== 2'b01 || md_opA !== 32'd21) begin nFail++; $display("FAIL rstmid_start: ctrl=%b opA=%0d want 01 21", {md_ctrl_mult, md_ctrl_div}, md_opA); end
        step(); step();
        md_resultRDY = 1; md_result = 7;
        step();
        md_resultRDY = 0; md_result = 0;
        #1;
        nChecks++; if (wb_valid !== 1'b1 || wb_lane !== 1'b1 || wb_rd !== 5'd12 || wb_data !== 32'd7) begin nFail++; $display("FAIL rstmid_wb: got v=%b lane=%b rd=%0d data=%0d want 1 1 12 7", wb_valid, wb_lane, wb_rd, wb_data); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_timeout();
        test_flush();
        test_exception();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/multdiv_arbiter.md
# multdiv_arbiter

Shares the single iterative multiply/divide unit between the top and bottom issue lanes of the dual-issue pipeline. It sits between the decode stage and the multdiv unit. It latches mult/div requests from a decode bundle and stalls decode while they are serviced. It issues the requests to the unit in program order (top before bottom) and returns each result to writeback tagged with its lane and destination register.

## Interface
Parameters:
- TIMEOUT, 64: cycles in WAIT without md_resultRDY before an exception result is forced (≥ 2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- valid_top, valid_bot  in  1  lane holds a live instruction.
- isMult_top, isDiv_top, isMult_bot, isDiv_bot  in  1  decoded op class. If both are set in one lane, the op is treated as mult.
- opA_top, opB_top, opA_bot, opB_bot  in  32  forwarded operands.
- rd_top, rd_bot  in  5  destination register.
- flush  in  1  kills the decode bundle (mispredict recovery).
- md_ctrl_mult, md_ctrl_div  out  1  one-cycle start pulse to the unit.
- md_opA, md_opB  out  32  operands to the unit, held for the whole operation.
- md_result  in  32; md_exception  in  1; md_resultRDY  in  1  one-cycle done pulse from the unit.
- stall  out  1  freezes fetch/decode.
- wb_valid  out  1; wb_lane  out  1 (0 = top, 1 = bot); wb_rd  out  5; wb_data  out  32; wb_exception  out  1.
- busy  out  1  state ≠ IDLE.

## Operation
- A lane request is req_x = valid_x & (isMult_x | isDiv_x).
- States:
  - IDLE: if (req_top | req_bot) & ~flush:
    - latch pend_top/pend_bot together with each lane's op type, operands and rd;
    - go to ISSUE.
  - ISSUE: select the oldest pending lane (top first).
    - Drive md_opA/md_opB from that lane's latched operands.
    - Pulse md_ctrl_mult or md_ctrl_div.
    - Clear the watchdog counter and go to WAIT.
  - WAIT: increment the counter each cycle.
    - On md_resultRDY: capture md_result/md_exception and go to DONE.
    - If the counter reaches TIMEOUT-1 first: capture data 0 with exception 1 and go to DONE.
  - DONE: drive wb_valid=1 with the captured lane/rd/data/exception.
    - Clear that lane's pend bit.
    - Go to ISSUE if the other pend bit is set, else go to IDLE.
  - DRAIN: entered on flush while in ISSUE or WAIT.
    - Wait for md_resultRDY or timeout, discard the result and go to IDLE.
    - No wb_valid is produced.
- stall is combinational:
  - IDLE: stall = (req_top | req_bot) & ~flush.
  - ISSUE, WAIT: stall = 1.
  - DONE: stall = 1 while the other lane is still pending, else 0. The decode bundle therefore advances on the edge that ends the last DONE.
  - DRAIN: stall = req_top | req_bot. A new bundle waits until the unit is free.
- flush handling:
  - In IDLE: requests in that cycle are ignored.
  - In ISSUE/WAIT: clear both pend bits and go to DRAIN. The start pulse is already sent because the unit cannot be aborted.
  - In DONE: suppress wb_valid and go to IDLE.
- md_resultRDY outside WAIT/DRAIN is ignored.
- md_opA/md_opB are held from ISSUE through WAIT. They read 0 in IDLE.

## Timing
- Reset (reset=0 at an edge): state IDLE, pend bits 0, counter 0. All outputs are 0: stall (if no request), md_ctrl_*, md_op*, wb_*, busy.
- Reset mid-operation abandons it. A later stray md_resultRDY is ignored.
- Single request: request seen in IDLE at cycle N.
  - N+1: ISSUE (start pulse).
  - N+2 onward: WAIT.
  - md_resultRDY at cycle M → DONE and wb_valid at M+1.
  - Stall covers N through M; it is low in M+1.
- Two requests: bot's ISSUE occurs at M+2, directly after top's DONE. There are no idle bubbles between lanes.
- Timeout: the exception result is delivered TIMEOUT+1 cycles after ISSUE.
- wb_valid is exactly one cycle per completed, unflushed op.

## Structure
- Shared package multdiv_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, DONE, DRAIN};
  - lane constants LANE_TOP=0, LANE_BOT=1;
  - the TIMEOUT default.
- One sub-module, multdiv_watchdog: clearable counter of width $clog2(TIMEOUT) with a terminal-count output. It is used in WAIT and DRAIN.
- Everything else lives in one FSM module.

## Test plan
- Top-only mult, opA=6, opB=7; unit returns 42 five cycles after start → one wb_valid with lane=0, rd=rd_top, data=42. Stall spans request cycle through resultRDY.
- Both lanes request: top div 100/7, bot mult 3×4 → top wb data=14, then bot wb data=12. Bot start pulse comes one cycle after top's wb. Stall drops only in bot's DONE.
- Unit never raises md_resultRDY, TIMEOUT=8 → wb_valid with data=0, exception=1, nine cycles after ISSUE.
- Flush during WAIT with bot pending; resultRDY arrives later → no wb_valid. State returns to IDLE the cycle after resultRDY. A new request during DRAIN holds stall=1 and is then issued.
- Divide exception: unit returns md_exception=1 → wb_exception=1 for that lane. A pending bot op still completes normally.
- Reset asserted in WAIT, then md_resultRDY pulses → all outputs 0, no wb_valid, next request is serviced normally.
